ddr3_read_control: RTL
======================

DDR3_READ_CONTROL -- requirements
Module: ddr3_read_control

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16: maximum number of issued read commands whose data has not yet returned, range 1..63.
REQ-002 SHALL have parameter APP_ADDR_W, default 27: DDR3 user-interface byte-address width.
REQ-003 ddr3_domain_clk  in  1  only clock, DDR3 user-interface clock; one clock, no other clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ddr3_rd_start_addr  in  23  address of the first 128-bit burst.
REQ-006 ddr3_rd_burst_cnt  in  24  number of bursts to read.
REQ-007 enable_reading  in  1  single-cycle start strobe.
REQ-008 reading_done  out  1  read sequence complete.
REQ-009 app_en  out  1  command valid to the DDR3 user interface.
REQ-010 app_cmd  out  3  command; always 3'b001 (read).
REQ-011 app_addr  out  APP_ADDR_W  command byte address.
REQ-012 app_rdy  in  1  user interface accepts the command.
REQ-013 app_rd_data  in  128  returned burst data.
REQ-014 app_rd_data_valid  in  1  app_rd_data is valid this cycle.
REQ-015 ddr3_rd_fifo_wr_en  out  1  write strobe to the read FIFO.
REQ-016 ddr3_rd_fifo_input_dat  out  128  burst data to the read FIFO.
REQ-017 ddr3_rd_fifo_input_tlast  out  1  marks the last burst of the sequence.
REQ-018 ddr3_rd_fifo_almost_full  in  1  read FIFO is nearly full.
REQ-019 ddr3_rd_sync_err  out  1  sticky flag: data returned that was never requested.

Function
REQ-020 The block SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-021 IDLE + enable_reading: latch start address and burst count, clear issued/returned counters; next state ISSUE, or DONE if burst count = 0.
REQ-022 app_addr SHALL equal {zero-extend, burst_addr[22:0], 3'b000}; the burst address SHALL increment by 1 per accepted command and wrap 0x7FFFFF -> 0x000000.
REQ-023 A command is accepted only in a cycle with app_en=1 and app_rdy=1; app_en, app_addr and app_cmd SHALL stay stable until accepted.
REQ-024 In ISSUE, app_en SHALL be asserted only when issued < count, outstanding < MAX_OUTSTANDING, and ddr3_rd_fifo_almost_full=0.
REQ-025 If almost_full rises while app_en=1 and app_rdy=0, the pending command SHALL be held, not withdrawn.
REQ-026 Outstanding SHALL be +1 on accept, -1 on data return, and unchanged when both occur in the same cycle.
REQ-027 ISSUE -> DRAIN on the cycle the last command is accepted.
REQ-028 DRAIN -> DONE on the cycle the last burst is returned.
REQ-029 Every app_rd_data_valid in ISSUE or DRAIN SHALL produce ddr3_rd_fifo_wr_en exactly 1 cycle later, with the data registered alongside it.
REQ-030 ddr3_rd_fifo_input_tlast SHALL be 1 only with the write of the burst whose returned count equals ddr3_rd_burst_cnt.
REQ-031 In DONE, reading_done SHALL be 1; it SHALL stay 1 until the next enable_reading in DONE, which restarts exactly as from IDLE.
REQ-032 enable_reading in ISSUE or DRAIN SHALL be ignored.
REQ-033 app_rd_data_valid in IDLE or DONE, or beyond the requested count, SHALL set ddr3_rd_sync_err and SHALL NOT write the FIFO.
REQ-034 Counter widths SHALL be 24 bits (issued, returned) and 6 bits (outstanding); no overflow is possible within the legal ranges.

Reset
REQ-035 Reset SHALL force state IDLE, clear all counters and registered data, and take effect in any state, including mid-sequence.
REQ-036 While reset=1 and after its release, all outputs SHALL be 0: app_en, app_addr, reading_done, ddr3_rd_fifo_wr_en, ddr3_rd_fifo_input_dat, ddr3_rd_fifo_input_tlast, ddr3_rd_sync_err.
REQ-037 app_cmd SHALL be 3'b001 at all times, including during reset.
REQ-038 Data returned after reset for commands issued before reset SHALL set ddr3_rd_sync_err.

Structure
REQ-039 A shared package ddr3_pkg SHALL hold the state enumeration, CMD_READ=3'b001, CMD_WRITE=3'b000, and the burst-to-byte shift value 3.
REQ-040 The block SHALL be flat, with the state machine, the address generator and the counters in one module and no sub-module.

Verification
REQ-041 start=0x000010, count=4, app_rdy=1, data returned 20 cycles later -> app_addr 0x80, 0x88, 0x90, 0x98; 4 FIFO writes; tlast on the 4th; reading_done=1.
REQ-042 count=0 -> no app_en; reading_done=1 two cycles after the strobe.
REQ-043 start=0x7FFFFE, count=3 -> burst addresses 0x7FFFFE, 0x7FFFFF, 0x000000.
REQ-044 count=40, MAX_OUTSTANDING=16, no data returned -> exactly 16 accepts, then app_en=0 until data returns; almost_full held for 50 cycles -> no new accepts during those cycles; a pending held command is still accepted.
REQ-045 Accept and data return in the same cycle, random app_rdy -> outstanding unchanged in those cycles; total of 40 writes in address order.
REQ-046 Reset asserted in DRAIN with 5 bursts outstanding -> all outputs 0; the 5 late bursts set ddr3_rd_sync_err and are not written.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 user-interface read path.
package ddr3_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  // 128-bit burst index to user-interface byte address.
  localparam int unsigned BURST_SHIFT = 3;

endpackage

// File: rtl/ddr3_read_control.sv
// Issues a run of 128-bit read bursts to the DDR3 user interface with flow control
// and forwards the returned data to the read FIFO, tagging the final burst.
module ddr3_read_control
  import ddr3_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned APP_ADDR_W      = 27
) (
  input  logic                  ddr3_domain_clk,
  input  logic                  reset,
  input  logic [22:0]           ddr3_rd_start_addr,
  input  logic [23:0]           ddr3_rd_burst_cnt,
  input  logic                  enable_reading,
  output logic                  reading_done,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [APP_ADDR_W-1:0] app_addr,
  input  logic                  app_rdy,
  input  logic [127:0]          app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  ddr3_rd_fifo_wr_en,
  output logic [127:0]          ddr3_rd_fifo_input_dat,
  output logic                  ddr3_rd_fifo_input_tlast,
  input  logic                  ddr3_rd_fifo_almost_full,
  output logic                  ddr3_rd_sync_err
);

  state_e      state;
  logic [22:0] burst_addr;
  logic [23:0] burst_cnt;
  logic [23:0] issued;
  logic [23:0] returned;
  logic [5:0]  outstanding;

  logic        accept;
  logic        busy;
  logic        ret_ok;
  logic        ret_bad;
  logic        issue_ok;
  logic [22:0] burst_addr_nxt;
  logic [23:0] issued_nxt;
  logic [5:0]  outstanding_nxt;

  assign app_cmd = CMD_READ;

  always_comb begin
    accept          = app_en & app_rdy;
    busy            = (state == StIssue) || (state == StDrain);
    // Data is legitimate only while a sequence runs and a command is still owed data.
    ret_ok          = app_rd_data_valid && busy && (returned < issued);
    ret_bad         = app_rd_data_valid && !ret_ok;
    burst_addr_nxt  = burst_addr + 23'(accept);
    issued_nxt      = issued + 24'(accept);
    outstanding_nxt = outstanding + 6'(accept) - 6'(ret_ok);
    issue_ok        = (issued_nxt < burst_cnt) &&
                      (32'(outstanding_nxt) < MAX_OUTSTANDING) &&
                      !ddr3_rd_fifo_almost_full;
  end

  always_ff @(posedge ddr3_domain_clk) begin
    if (reset) begin
      state                    <= StIdle;
      burst_addr               <= '0;
      burst_cnt                <= '0;
      issued                   <= '0;
      returned                 <= '0;
      outstanding              <= '0;
      reading_done             <= 1'b0;
      app_en                   <= 1'b0;
      app_addr                 <= '0;
      ddr3_rd_fifo_wr_en       <= 1'b0;
      ddr3_rd_fifo_input_dat   <= '0;
      ddr3_rd_fifo_input_tlast <= 1'b0;
      ddr3_rd_sync_err         <= 1'b0;
    end else begin
      ddr3_rd_fifo_wr_en       <= 1'b0;
      ddr3_rd_fifo_input_tlast <= 1'b0;
      if (ret_bad) begin
        ddr3_rd_sync_err <= 1'b1;
      end
      if (ret_ok) begin
        ddr3_rd_fifo_wr_en       <= 1'b1;
        ddr3_rd_fifo_input_dat   <= app_rd_data;
        ddr3_rd_fifo_input_tlast <= (returned + 24'd1 == burst_cnt);
        returned                 <= returned + 24'd1;
      end

      unique case (state)
        StIdle, StDone: begin
          reading_done <= (state == StDone);
          if (enable_reading) begin
            burst_addr   <= ddr3_rd_start_addr;
            burst_cnt    <= ddr3_rd_burst_cnt;
            issued       <= '0;
            returned     <= '0;
            outstanding  <= '0;
            reading_done <= 1'b0;
            app_addr     <= APP_ADDR_W'(ddr3_rd_start_addr) << BURST_SHIFT;
            app_en       <= (ddr3_rd_burst_cnt != 24'd0) && !ddr3_rd_fifo_almost_full;
            state        <= (ddr3_rd_burst_cnt == 24'd0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          burst_addr  <= burst_addr_nxt;
          issued      <= issued_nxt;
          outstanding <= outstanding_nxt;
          app_addr    <= APP_ADDR_W'(burst_addr_nxt) << BURST_SHIFT;
          // A presented command is never withdrawn, whatever the FIFO says.
          if (app_en && !app_rdy) begin
            app_en <= 1'b1;
          end else if (issued_nxt == burst_cnt) begin
            app_en <= 1'b0;
            state  <= StDrain;
          end else begin
            app_en <= issue_ok;
          end
        end
        StDrain: begin
          outstanding <= outstanding_nxt;
          if (ret_ok && (returned + 24'd1 == burst_cnt)) begin
            state <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
